// File: rtl/aes_pkg.sv
// Shared AES state types and demux select encodings.
// Types only; no logic, no latency, no flow control.
package aes_pkg;
  typedef logic [7:0] byte_t;
  typedef byte_t [0:3][0:3] state_t;

  localparam logic SEL_FEEDBACK = 1'b0;
  localparam logic SEL_OUTPUT   = 1'b1;
endpackage

// File: rtl/aes_state_hold.sv
// Single-entry AES state holding register with accepted-block counter.
// Load to valid: 1 cycle. Holds data while valid & !ready; drain + load same edge sustains 1/cycle.
// AES_DEMUX_ZEROIZE_EN: clear the data register on a drain with no simultaneous load.
module aes_state_hold
  import aes_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter bit ZERO_ON_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  state_t           load_state,
  output state_t           state,
  output logic             valid,
  input  logic             ready,
  output logic             free,
  output logic [CNT_W-1:0] cnt
);

  assign free = !valid | ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      cnt   <= cnt + CNT_W'(1);
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  // Data has no reset unless ZERO_ON_IDLE asks for one; valid alone marks it meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (ZERO_ON_IDLE) state <= '0;
    end else if (load) begin
      state <= load_state;
    end
`ifdef AES_DEMUX_ZEROIZE_EN
    else if (valid && ready) begin
      state <= '0;
    end
`endif
  end

endmodule

// File: rtl/aes_state_demux.sv
// Registered 1-to-2 demux of the AES state: sink 0 round feedback, sink 1 output stage.
// Latency 1 cycle; in_ready follows the selected channel's free flag, stalled channel never blocks the other.
// Optional AES_DEMUX_ZEROIZE_EN clears drained holding registers.
module aes_state_demux
  import aes_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter bit ZERO_ON_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  state_t           in_state,
  input  logic             in_valid,
  input  logic             in_sel,
  output logic             in_ready,
  output state_t           out0_state,
  output logic             out0_valid,
  input  logic             out0_ready,
  output state_t           out1_state,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);

  logic free0, free1;
  logic load0, load1;

  assign in_ready = (in_sel == SEL_OUTPUT) ? free1 : free0;
  assign load0    = in_valid & in_ready & (in_sel == SEL_FEEDBACK);
  assign load1    = in_valid & in_ready & (in_sel == SEL_OUTPUT);
  assign busy     = out0_valid | out1_valid;

  aes_state_hold #(.CNT_W(CNT_W), .ZERO_ON_IDLE(ZERO_ON_IDLE)) u_hold0 (
    .clk        (clk),
    .rst        (rst),
    .load       (load0),
    .load_state (in_state),
    .state      (out0_state),
    .valid      (out0_valid),
    .ready      (out0_ready),
    .free       (free0),
    .cnt        (cnt0)
  );

  aes_state_hold #(.CNT_W(CNT_W), .ZERO_ON_IDLE(ZERO_ON_IDLE)) u_hold1 (
    .clk        (clk),
    .rst        (rst),
    .load       (load1),
    .load_state (in_state),
    .state      (out1_state),
    .valid      (out1_valid),
    .ready      (out1_ready),
    .free       (free1),
    .cnt        (cnt1)
  );

endmodule

// File: tb/tb_aes_state_demux.sv
// Scoreboard bench for aes_state_demux: expected blocks queued per channel, monitor checks each output handshake.
module tb_aes_state_demux;
  import aes_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  state_t           in_state;
  logic             in_valid;
  logic             in_sel;
  logic             in_ready;
  state_t           out0_state, out1_state;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic             busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  state_t q0[$];
  state_t q1[$];

  always #5 clk = ~clk;

  aes_state_demux #(.CNT_W(CNT_W), .ZERO_ON_IDLE(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_state   (in_state),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .out0_state (out0_state),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_state (out1_state),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: a handshake seen mid-cycle completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) chk("ch0 unexpected block", 128'd1, 128'd0);
        else chk("ch0 data", out0_state, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) chk("ch1 unexpected block", 128'd1, 128'd0);
        else chk("ch1 data", out1_state, q1.pop_front());
      end
    end
  end

  // Present one block and hold it until accepted; leaves at posedge+1 after the accepting edge.
  task automatic send(input logic sel, input state_t st);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_state = st;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (sel) q1.push_back(st);
        else     q0.push_back(st);
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) chk("send timeout", 128'd0, 128'd1);
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  state_t s_inc, s_key, s_a, s_b, st;
  int     ready_drops;

  initial begin
    s_inc = 128'h000102030405060708090A0B0C0D0E0F;
    s_key = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    s_a   = 128'hA5A5A5A5_11111111_22222222_33333333;
    s_b   = 128'h5A5A5A5A_44444444_55555555_66666666;

    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_state = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out0_valid", out0_valid, 0);
    chk("reset out1_valid", out1_valid, 0);
    chk("reset cnt0", cnt0, 0);
    chk("reset cnt1", cnt1, 0);
    chk("reset busy", busy, 0);
    chk("reset out0_state", out0_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset while channel 1 holds a block
    send(1'b1, s_inc);
    @(negedge clk);
    chk("ch1 loaded valid", out1_valid, 1);
    chk("ch1 loaded cnt1", cnt1, 1);
    chk("busy while held", busy, 1);
    @(posedge clk); #1;
    pulse_reset();
    @(negedge clk);
    chk("midrst out1_valid", out1_valid, 0);
    chk("midrst cnt1", cnt1, 0);
    chk("midrst out1_state", out1_state, 0);
    chk("midrst busy", busy, 0);

    // Basic routing to channel 0, exactly one cycle latency
    @(posedge clk); #1;
    out0_ready = 1'b1;
    send(1'b0, s_key);
    @(negedge clk);
    chk("route out0_valid", out0_valid, 1);
    chk("route out1_valid", out1_valid, 0);
    chk("route cnt0", cnt0, 1);
    @(negedge clk);
    chk("drained out0_valid", out0_valid, 0);
`ifdef AES_DEMUX_ZEROIZE_EN
    chk("zeroize out0_state", out0_state, 0);
`else
    chk("retain out0_state", out0_state, s_key);
`endif

    // Back-pressure on channel 1
    @(posedge clk); #1;
    out1_ready = 1'b0;
    send(1'b1, s_a);
    in_valid = 1'b1; in_sel = 1'b1; in_state = s_b;
    @(negedge clk);
    chk("stall A held", out1_state, s_a);
    chk("stall in_ready sel1", in_ready, 0);
    in_sel = 1'b0;
    #1 chk("stall in_ready sel0", in_ready, 1);
    in_sel = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall A still held", out1_state, s_a);
    @(posedge clk); #1;
    out1_ready = 1'b1;
    q1.push_back(s_b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("swap out1_valid", out1_valid, 1);
    chk("swap out1_state", out1_state, s_b);
    chk("swap cnt1", cnt1, 2);

    // Throughput: 16 alternating blocks, both sinks ready
    @(posedge clk); #1;
    pulse_reset();
    out0_ready = 1'b1; out1_ready = 1'b1;
    ready_drops = 0;
    for (int i = 0; i < 16; i++) begin
      st = {16{8'(i * 17 + 3)}};
      in_valid = 1'b1; in_sel = i[0]; in_state = st;
      if (i[0]) q1.push_back(st);
      else      q0.push_back(st);
      @(negedge clk);
      if (!in_ready) ready_drops++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("thru in_ready drops", ready_drops, 0);
    @(negedge clk);
    chk("thru cnt0", cnt0, 8);
    chk("thru cnt1", cnt1, 8);

    // Counter wrap: 17 accepts into a 4-bit counter
    @(posedge clk); #1;
    pulse_reset();
    for (int i = 0; i < 17; i++) begin
      st = {4{32'(i + 32'hC0DE0000)}};
      in_valid = 1'b1; in_sel = 1'b0; in_state = st;
      q0.push_back(st);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrap cnt0", cnt0, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    chk("final busy", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
